// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester-side and register-file-side signals of the write arbiter
interface regfile_write_arbiter_if #(
    parameter int S = 2,
    parameter int N = 16,
    parameter int R = 3
);
    localparam int L = 2 ** S;

    logic           gwe;
    logic [L-1:0]   req;
    logic [L*R-1:0] wsel_in;
    logic [L*N-1:0] wdata_in;
    logic [L-1:0]   grant;
    logic [S-1:0]   grant_idx;
    logic           grant_valid;
    logic           rf_we;
    logic [R-1:0]   rf_wsel;
    logic [N-1:0]   rf_wdata;

    modport master (
        output gwe, req, wsel_in, wdata_in,
        input  grant, grant_idx, grant_valid, rf_we, rf_wsel, rf_wdata
    );

    modport slave (
        input  gwe, req, wsel_in, wdata_in,
        output grant, grant_idx, grant_valid, rf_we, rf_wsel, rf_wdata
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin owner of the register-file write port with bounded bursts
module regfile_write_arbiter #(
    parameter int S         = 2,
    parameter int N         = 16,
    parameter int R         = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_write_arbiter_if.slave bus
);
    localparam int L  = 2 ** S;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t        state_q, state_d;
    logic [S-1:0]  owner_q, owner_d;
    logic [S-1:0]  ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          own_req;
    logic          cnt_last;
    logic [L-1:0]  others;
    logic [S-1:0]  pick_ptr;
    logic [S-1:0]  pick_next;

    // First set bit of mask scanning start, start+1, ... with wrap.
    function automatic logic [S-1:0] rr_pick(input logic [L-1:0] mask, input logic [S-1:0] start);
        logic [S-1:0] idx;
        logic [S-1:0] res;
        logic         found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < L; i++) begin
            idx = start + S'(i);
            if (mask[idx] && !found) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign own_req   = bus.req[owner_q];
    assign others    = bus.req & ~(L'(1) << owner_q);
    assign cnt_last  = (cnt_q == CW'(MAX_BURST - 1));
    assign pick_ptr  = rr_pick(bus.req, ptr_q);
    assign pick_next = rr_pick(others, owner_q + S'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (bus.gwe) begin
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        state_d = OWNED;
                        owner_d = pick_ptr;
                        cnt_d   = '0;
                        ptr_d   = pick_ptr + S'(1);
                    end
                end
                OWNED: begin
                    if (!own_req) begin
                        // Owner released: hand over in the same edge, no dead cycle.
                        if (|others) begin
                            owner_d = pick_ptr;
                            cnt_d   = '0;
                            ptr_d   = pick_ptr + S'(1);
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else if (!cnt_last) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (|others) begin
                        owner_d = pick_next;
                        cnt_d   = '0;
                        ptr_d   = pick_next + S'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.grant_valid = (state_q == OWNED);
        bus.grant       = '0;
        bus.grant_idx   = '0;
        bus.rf_wsel     = '0;
        bus.rf_wdata    = '0;
        bus.rf_we       = 1'b0;
        if (state_q == OWNED) begin
            bus.grant     = L'(1) << owner_q;
            bus.grant_idx = owner_q;
            bus.rf_wsel   = bus.wsel_in[owner_q*R +: R];
            bus.rf_wdata  = bus.wdata_in[owner_q*N +: N];
            bus.rf_we     = own_req & bus.gwe;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for the register-file write arbiter
module tb_regfile_write_arbiter;
    localparam int S = 2;
    localparam int N = 16;
    localparam int R = 3;
    localparam int L = 4;

    typedef struct packed {
        logic        valid;
        logic [1:0]  idx;
        logic [3:0]  grant;
        logic        we;
        logic [2:0]  wsel;
        logic [15:0] wdata;
    } snap_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    snap_t exp_q[$];

    logic [2:0]  lane_wsel [L];
    logic [15:0] lane_wdata[L];

    regfile_write_arbiter_if #(.S(S), .N(N), .R(R)) bus();

    regfile_write_arbiter #(.S(S), .N(N), .R(R), .MAX_BURST(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t mk(input bit v, input int idx, input bit we);
        snap_t s;
        s.valid = v;
        s.idx   = v ? 2'(idx) : 2'd0;
        s.grant = v ? (4'b0001 << idx) : 4'b0000;
        s.we    = we;
        s.wsel  = v ? lane_wsel[idx] : 3'd0;
        s.wdata = v ? lane_wdata[idx] : 16'd0;
        return s;
    endfunction

    function automatic snap_t observe();
        snap_t s;
        s.valid = bus.grant_valid;
        s.idx   = bus.grant_idx;
        s.grant = bus.grant;
        s.we    = bus.rf_we;
        s.wsel  = bus.rf_wsel;
        s.wdata = bus.rf_wdata;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("v=%b idx=%0d g=%b we=%b ws=%0d wd=%h", s.valid, s.idx, s.grant, s.we, s.wsel, s.wdata);
    endfunction

    task automatic set_lanes();
        for (int j = 0; j < L; j++) begin
            bus.wsel_in[j*R +: R]  = lane_wsel[j];
            bus.wdata_in[j*N +: N] = lane_wdata[j];
        end
    endtask

    task automatic default_lanes();
        for (int j = 0; j < L; j++) begin
            lane_wsel[j]  = 3'(j + 4);
            lane_wdata[j] = 16'hA0A0 ^ (16'h1111 * 16'(j + 1));
        end
        set_lanes();
    endtask

    task automatic drive(input logic [3:0] r, input logic g, input logic rs);
        @(negedge clk);
        rst     = rs;
        bus.req = r;
        bus.gwe = g;
    endtask

    task automatic do_reset(input logic [3:0] r);
        drive(r, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        snap_t e, o;
        drive(4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(4'hF, 1'(i), 1'b1);
            exp_q.push_back(mk(0, 0, 0));
            #1;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d] got %s exp %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] reqs[4] = '{4'h1, 4'h1, 4'h0, 4'h0};
        bit         ev[4]   = '{0, 1, 1, 0};
        bit         ew[4]   = '{0, 1, 0, 0};
        snap_t e, o;
        do_reset(4'h0);
        lane_wsel[0]  = 3'd3;
        lane_wdata[0] = 16'hBEEF;
        set_lanes();
        for (int c = 0; c < 4; c++) begin
            drive(reqs[c], 1'b1, 1'b0);
            exp_q.push_back(mk(ev[c], 0, ew[c]));
            #1;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single[%0d] got %s exp %s", c, fmt(o), fmt(e));
            end
        end
        default_lanes();
    endtask

    task automatic test_round_robin();
        snap_t e, o;
        do_reset(4'hF);
        for (int k = 0; k < 21; k++) begin
            drive(4'hF, 1'b1, 1'b0);
            if (k == 0) exp_q.push_back(mk(0, 0, 0));
            else        exp_q.push_back(mk(1, ((k - 1) / 4) % 4, 1));
            #1;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL round_robin[%0d] got %s exp %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_burst_no_compete();
        snap_t e, o;
        do_reset(4'h0);
        for (int k = 0; k < 13; k++) begin
            drive(4'h4, 1'b1, 1'b0);
            if (k == 0) exp_q.push_back(mk(0, 0, 0));
            else        exp_q.push_back(mk(1, 2, 1));
            #1;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL burst_alone[%0d] got %s exp %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_handoff();
        logic [3:0] reqs[7] = '{4'h2, 4'h2, 4'h2, 4'h8, 4'h8, 4'h0, 4'h0};
        bit         ev[7]   = '{0, 1, 1, 1, 1, 1, 0};
        int         ei[7]   = '{0, 1, 1, 1, 3, 3, 0};
        bit         ew[7]   = '{0, 1, 1, 0, 1, 0, 0};
        snap_t e, o;
        do_reset(4'h0);
        for (int c = 0; c < 7; c++) begin
            drive(reqs[c], 1'b1, 1'b0);
            exp_q.push_back(mk(ev[c], ei[c], ew[c]));
            #1;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL handoff[%0d] got %s exp %s", c, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_gwe_freeze();
        logic gw[10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
        bit   ev[10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        int   ei[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        bit   ew[10] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 1};
        snap_t e, o;
        do_reset(4'h0);
        for (int c = 0; c < 10; c++) begin
            drive(4'h3, gw[c], 1'b0);
            exp_q.push_back(mk(ev[c], ei[c], ew[c]));
            #1;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL gwe_freeze[%0d] got %s exp %s", c, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        snap_t e, o;
        do_reset(4'h0);
        for (int k = 0; k < 15; k++) begin
            if (k <= 10)      drive(4'hF, 1'b1, 1'b0);
            else if (k == 11) drive(4'hF, 1'b1, 1'b1);
            else              drive(4'hA, 1'b1, 1'b0);
            if (k == 0 || k == 12) exp_q.push_back(mk(0, 0, 0));
            else if (k <= 11)      exp_q.push_back(mk(1, ((k - 1) / 4) % 4, 1));
            else                   exp_q.push_back(mk(1, 1, 1));
            #1;
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid_burst[%0d] got %s exp %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_invariants();
        logic [3:0] r;
        logic       g;
        snap_t      o;
        logic       exp_we;
        do_reset(4'h0);
        for (int k = 0; k < 300; k++) begin
            r = 4'($urandom_range(0, 15));
            g = ($urandom_range(0, 3) != 0);
            drive(r, g, 1'b0);
            #1;
            o = observe();
            checks++;
            if ((o.grant & (o.grant - 4'd1)) !== 4'd0) begin
                errors++;
                $display("FAIL inv_onehot[%0d] got grant=%b exp one-hot or zero", k, o.grant);
            end
            checks++;
            if (o.valid !== (|o.grant)) begin
                errors++;
                $display("FAIL inv_valid[%0d] got valid=%b exp %b", k, o.valid, |o.grant);
            end
            checks++;
            if (o.grant !== (o.valid ? (4'b0001 << o.idx) : 4'b0000) || (!o.valid && o.idx !== 2'd0)) begin
                errors++;
                $display("FAIL inv_idx[%0d] got idx=%0d grant=%b", k, o.idx, o.grant);
            end
            exp_we = o.valid & r[o.idx] & g;
            checks++;
            if (o.we !== exp_we) begin
                errors++;
                $display("FAIL inv_we[%0d] got %b exp %b", k, o.we, exp_we);
            end
            checks++;
            if (o.wsel !== (o.valid ? lane_wsel[o.idx] : 3'd0) ||
                o.wdata !== (o.valid ? lane_wdata[o.idx] : 16'd0)) begin
                errors++;
                $display("FAIL inv_lane[%0d] got ws=%0d wd=%h idx=%0d", k, o.wsel, o.wdata, o.idx);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.req = '0;
        bus.gwe = 1'b0;
        default_lanes();
        test_reset();
        test_single();
        test_round_robin();
        test_burst_no_compete();
        test_handoff();
        test_gwe_freeze();
        test_reset_mid_burst();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
